// File: rtl/phase_scheduler.sv
// Four-phase traffic-light sequencer: per-cycle latched priority/congestion
// config sets green times; GREEN/YELLOW stepping on a 1 Hz tick with BCD countdown.
module phase_scheduler #(
  parameter int YELLOW_T = 5,
  parameter int T_EQ     = 44,
  parameter int T_HI1    = 55,
  parameter int T_LO1    = 33,
  parameter int T_HI2    = 66,
  parameter int T_LO2    = 22
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       tick,
  input  logic       count_en,
  input  logic [1:0] speed_select,
  input  logic [2:0] flowspeed,
  output logic [1:0] phase,
  output logic       is_yellow,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       cycle_start
);

  typedef enum logic {S_GREEN = 1'b0, S_YELLOW = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] phase_q, phase_d, sel_q, sel_d, lvl_q, lvl_d;
  logic [6:0] cnt_q, cnt_d;
  logic [3:0] green_q, green_d, yellow_q, yellow_d;
  logic       cs_q, cs_d;
  logic       adv;

  function automatic logic [1:0] decode_level(input logic [2:0] f);
    case (f)
      3'b001:         return 2'd1;
      3'b011, 3'b111: return 2'd2;
      default:        return 2'd0;
    endcase
  endfunction

  function automatic logic [6:0] green_time(input logic [1:0] p, input logic [1:0] sel,
                                            input logic [1:0] lvl);
    case (lvl)
      2'd1:    return (p == sel) ? 7'(T_HI1) : 7'(T_LO1);
      2'd2:    return (p == sel) ? 7'(T_HI2) : 7'(T_LO2);
      default: return 7'(T_EQ);
    endcase
  endfunction

  assign adv = tick & count_en;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sel_d   = sel_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    cs_d    = 1'b0;
    if (adv) begin
      if (cnt_q != 7'd1) begin
        cnt_d = cnt_q - 7'd1;
      end else if (state_q == S_GREEN) begin
        state_d = S_YELLOW;
        cnt_d   = 7'(YELLOW_T);
      end else begin
        state_d = S_GREEN;
        phase_d = phase_q + 2'd1;
        // Config is latched on the wrap so phase 0 already sees the new setting.
        if (phase_q == 2'd3) begin
          sel_d = speed_select;
          lvl_d = decode_level(flowspeed);
          cnt_d = green_time(2'd0, speed_select, decode_level(flowspeed));
          cs_d  = 1'b1;
        end else begin
          cnt_d = green_time(phase_d, sel_q, lvl_q);
        end
      end
    end
    green_d  = '0;
    yellow_d = '0;
    if (state_d == S_YELLOW) yellow_d[phase_d] = 1'b1;
    else                     green_d[phase_d]  = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q  <= S_GREEN;
      phase_q  <= 2'd0;
      sel_q    <= speed_select;
      lvl_q    <= decode_level(flowspeed);
      cnt_q    <= green_time(2'd0, speed_select, decode_level(flowspeed));
      green_q  <= 4'b0001;
      yellow_q <= 4'b0000;
      cs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      sel_q    <= sel_d;
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      cs_q     <= cs_d;
    end
  end

  // Count never exceeds 99, so a compare chain covers the tens digit.
  always_comb begin
    cnt_tens = 4'd0;
    for (int i = 1; i < 10; i++)
      if (cnt_q >= 7'(10 * i)) cnt_tens = 4'(i);
    cnt_ones = 4'(cnt_q - 7'(10 * cnt_tens));
  end

  assign phase       = phase_q;
  assign is_yellow   = (state_q == S_YELLOW);
  assign green       = green_q;
  assign yellow      = yellow_q;
  assign red         = ~green_q & ~yellow_q;
  assign cycle_start = cs_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: cycle-by-cycle scoreboard against a behavioural
// model, plus phase-length measurements against tabulated green times.
module tb_phase_scheduler;
  logic       CLK = 1'b0, Reset = 1'b0, tick = 1'b0, count_en = 1'b0;
  logic [1:0] speed_select = 2'd0;
  logic [2:0] flowspeed = 3'd0;
  logic [1:0] phase;
  logic       is_yellow, cycle_start;
  logic [3:0] green, yellow, red, cnt_tens, cnt_ones;

  phase_scheduler dut (
    .CLK(CLK), .Reset(Reset), .tick(tick), .count_en(count_en),
    .speed_select(speed_select), .flowspeed(flowspeed),
    .phase(phase), .is_yellow(is_yellow), .green(green), .yellow(yellow),
    .red(red), .cnt_tens(cnt_tens), .cnt_ones(cnt_ones), .cycle_start(cycle_start)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] ph; logic y; logic [3:0] t, o, g, yl, r; logic cs;
  } obs_t;

  typedef struct {
    int sel; int fl; int g0; int g1; int g2; int g3;
  } vec_t;

  obs_t exp_q[$];
  int   checks = 0, errors = 0, cs_cnt = 0;
  int   m_ph = 0, m_cnt = 0, m_sel = 0, m_lvl = 0;
  bit   m_y = 0, m_cs = 0;

  function automatic int lvl_of(input logic [2:0] f);
    case (f)
      3'b001:         return 1;
      3'b011, 3'b111: return 2;
      default:        return 0;
    endcase
  endfunction

  function automatic int gt(input int p, input int sel, input int lvl);
    if (lvl == 1) return (p == sel) ? 55 : 33;
    if (lvl == 2) return (p == sel) ? 66 : 22;
    return 44;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step(input bit rst, input bit tk, input bit en);
    obs_t e, a;
    @(negedge CLK);
    Reset = rst; tick = tk; count_en = en;
    if (!rst) begin
      m_sel = speed_select; m_lvl = lvl_of(flowspeed);
      m_ph = 0; m_y = 0; m_cs = 0; m_cnt = gt(0, m_sel, m_lvl);
    end else begin
      m_cs = 0;
      if (tk && en) begin
        if (m_cnt > 1) m_cnt--;
        else if (!m_y) begin m_y = 1; m_cnt = 5; end
        else begin
          m_y = 0; m_ph = (m_ph + 1) % 4;
          if (m_ph == 0) begin
            m_sel = speed_select; m_lvl = lvl_of(flowspeed); m_cs = 1;
          end
          m_cnt = gt(m_ph, m_sel, m_lvl);
        end
      end
    end
    e.ph = 2'(m_ph); e.y = m_y;
    e.t = 4'(m_cnt / 10); e.o = 4'(m_cnt % 10);
    e.g  = m_y ? 4'b0000 : (4'b0001 << m_ph);
    e.yl = m_y ? (4'b0001 << m_ph) : 4'b0000;
    e.r  = ~(e.g | e.yl);
    e.cs = m_cs;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    a.ph = phase; a.y = is_yellow; a.t = cnt_tens; a.o = cnt_ones;
    a.g = green; a.yl = yellow; a.r = red; a.cs = cycle_start;
    e = exp_q.pop_front();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t: got ph=%0d y=%b cnt=%0d%0d g=%b yl=%b r=%b cs=%b expected ph=%0d y=%b cnt=%0d%0d g=%b yl=%b r=%b cs=%b",
               $time, a.ph, a.y, a.t, a.o, a.g, a.yl, a.r, a.cs,
               e.ph, e.y, e.t, e.o, e.g, e.yl, e.r, e.cs);
    end
    if (cycle_start) cs_cnt++;
  endtask

  task automatic tick_step();
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int sel, input int fl);
    speed_select = 2'(sel); flowspeed = 3'(fl);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic measure_phase(input int p, input int eg);
    int n;
    chk($sformatf("entry_phase_p%0d", p), int'(phase), p);
    chk($sformatf("entry_green_p%0d", p), int'(is_yellow), 0);
    chk($sformatf("entry_tens_p%0d", p), int'(cnt_tens), eg / 10);
    chk($sformatf("entry_ones_p%0d", p), int'(cnt_ones), eg % 10);
    n = 0;
    do begin tick_step(); n++; end while (!is_yellow && n < 150);
    chk($sformatf("green_len_p%0d", p), n, eg);
    n = 0;
    do begin tick_step(); n++; end while (is_yellow && n < 150);
    chk($sformatf("yellow_len_p%0d", p), n, 5);
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{sel: 0, fl: 0, g0: 44, g1: 44, g2: 44, g3: 44};
    vt[1] = '{sel: 2, fl: 1, g0: 33, g1: 33, g2: 55, g3: 33};
    vt[2] = '{sel: 1, fl: 7, g0: 22, g1: 66, g2: 22, g3: 22};
    vt[3] = '{sel: 3, fl: 3, g0: 22, g1: 22, g2: 22, g3: 66};
    vt[4] = '{sel: 0, fl: 2, g0: 44, g1: 44, g2: 44, g3: 44};
    vt[5] = '{sel: 1, fl: 5, g0: 44, g1: 44, g2: 44, g3: 44};

    for (int i = 0; i < 6; i++) begin
      int ga[4];
      ga = '{vt[i].g0, vt[i].g1, vt[i].g2, vt[i].g3};
      do_reset(vt[i].sel, vt[i].fl);
      chk("rst_phase", int'(phase), 0);
      chk("rst_green", int'(green), 1);
      chk("rst_yellow", int'(yellow), 0);
      chk("rst_red", int'(red), 14);
      chk("rst_tens", int'(cnt_tens), ga[0] / 10);
      chk("rst_ones", int'(cnt_ones), ga[0] % 10);
      chk("rst_cs", int'(cycle_start), 0);
      cs_cnt = 0;
      for (int p = 0; p < 4; p++) measure_phase(p, ga[p]);
      chk($sformatf("cycle_start_count_v%0d", i), cs_cnt, 1);
    end

    // Mid-cycle congestion change only takes effect at the next cycle start.
    do_reset(1, 0);
    measure_phase(0, 44);
    flowspeed = 3'b111;
    for (int p = 1; p < 4; p++) measure_phase(p, 44);
    for (int p = 0; p < 4; p++) measure_phase(p, (p == 1) ? 66 : 22);

    // Ticks dropped while count_en is low.
    do_reset(0, 0);
    repeat (14) tick_step();
    chk("hold_pre_tens", int'(cnt_tens), 3);
    chk("hold_pre_ones", int'(cnt_ones), 0);
    repeat (10) step(1'b1, 1'b1, 1'b0);
    chk("hold_tens", int'(cnt_tens), 3);
    chk("hold_ones", int'(cnt_ones), 0);
    chk("hold_green", int'(green), 1);
    tick_step();
    chk("resume_tens", int'(cnt_tens), 2);
    chk("resume_ones", int'(cnt_ones), 9);

    // Reset colliding with a tick in phase 2 yellow.
    do_reset(0, 0);
    repeat (144) tick_step();
    chk("pre_rst_phase", int'(phase), 2);
    chk("pre_rst_yellow", int'(is_yellow), 1);
    speed_select = 2'd0; flowspeed = 3'b001;
    step(1'b0, 1'b1, 1'b1);
    chk("midrst_phase", int'(phase), 0);
    chk("midrst_yel", int'(is_yellow), 0);
    chk("midrst_green", int'(green), 1);
    chk("midrst_tens", int'(cnt_tens), 5);
    chk("midrst_ones", int'(cnt_ones), 5);
    chk("midrst_cs", int'(cycle_start), 0);
    step(1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
- Four-phase green-time scheduler and sequencer for the intersection light datapath.
- Latches the priority direction and congestion level once per full cycle and derives per-phase green durations from them.
- Steps phases 0..3 through GREEN then YELLOW on a 1 Hz tick strobe.
- Drives one-hot per-direction lamp outputs and a two-digit BCD countdown for the seven-segment path.

Parameters:
- YELLOW_T, 5, yellow duration in ticks; legal range 1..99
- T_EQ, 44, green ticks per phase when no direction is prioritised
- T_HI1, 55, prioritised-phase green at level 1
- T_LO1, 33, non-prioritised green at level 1
- T_HI2, 66, prioritised-phase green at level 2
- T_LO2, 22, non-prioritised green at level 2
- All T_* legal range 1..99; 0 is illegal.

Ports:
- CLK  in  1  system clock
- Reset  in  1  synchronous active-low reset, sampled on posedge CLK
- tick  in  1  one-CLK-wide 1 Hz strobe from the divider
- count_en  in  1  run enable; low freezes sequencing
- speed_select  in  2  prioritised phase index 0..3
- flowspeed  in  3  congestion code
- phase  out  2  current phase index
- is_yellow  out  1  1 = YELLOW interval, 0 = GREEN interval
- green  out  4  one-hot green lamp; bit n = phase n
- yellow  out  4  one-hot yellow lamp
- red  out  4  red lamps (~green & ~yellow)
- cnt_tens  out  4  BCD tens digit of remaining ticks
- cnt_ones  out  4  BCD ones digit of remaining ticks
- cycle_start  out  1  one-CLK pulse on entry to phase 0 GREEN

Behaviour:
- Clock and reset: one clock domain, CLK. Reset is synchronous and active-low: Reset==0 at posedge CLK resets. Reset has priority over tick and count_en.
- Level decode from flowspeed:
  - 3'b000 → level 0.
  - 3'b001 → level 1.
  - 3'b011 or 3'b111 → level 2.
  - Every other code → level 0.
- Green table, for phase p with latched sel and level:
  - Level 0: T_EQ.
  - Level 1: T_HI1 if p==sel, else T_LO1.
  - Level 2: T_HI2 if p==sel, else T_LO2.
- Config registers cfg_sel and cfg_level:
  - Loaded from the inputs during reset.
  - Loaded at every phase 3 → phase 0 transition.
  - Otherwise held. Mid-cycle input changes have no effect until the next cycle start.
- Reset values:
  - phase=0, is_yellow=0, cnt=green(0) computed from the inputs present during reset.
  - green=4'b0001, yellow=0, red=4'b1110, cycle_start=0.
- Advance condition: adv = tick & count_en & Reset. When adv=0, all state holds; cycle_start=0.
- GREEN state, on adv:
  - If cnt==1: go to YELLOW, cnt←YELLOW_T.
  - Else: cnt←cnt-1.
- YELLOW state, on adv:
  - If cnt==1: phase←phase+1 (mod 4, 3 wraps to 0), go to GREEN, cnt←green(new phase).
  - On the 3→0 wrap, the new config is latched first; green(0) uses the new config in the same cycle, and cycle_start=1 for that one CLK.
  - Else: cnt←cnt-1.
- Each GREEN lasts exactly green(p) ticks. Each YELLOW lasts exactly YELLOW_T ticks. Full cycle length is the sum of the four greens plus 4*YELLOW_T.
- cnt is 7 bits and is never 0 after reset.
- cnt_tens = cnt/10 and cnt_ones = cnt%10, combinational from cnt (zero latency); max displayed value 99.
- Lamp outputs are registered, updated in the same edge as phase/is_yellow:
  - green[phase] = ~is_yellow.
  - yellow[phase] = is_yellow.
  - Exactly one of green|yellow is set at all times; red is its complement.
- A tick arriving while count_en==0 is dropped, not queued.
- Reset asserted mid-phase returns to phase 0 GREEN on the next edge, regardless of tick.

Test Plan:
- Reset with flowspeed=000, then 176+20 ticks → phases 0,1,2,3, each green 44 ticks and yellow 5 ticks; cnt shows 4/4 right after reset; cycle_start pulses once, at tick 196.
- speed_select=2, flowspeed=001 held through reset → phase 0 green=33, phase 2 green=55 (display 5/5 on entry); cycle length 174 ticks.
- flowspeed changed 000→111 with speed_select=1 during phase 1 → current cycle keeps 44s; next cycle gives phase 1 green=66 and others 22.
- count_en=0 for 10 ticks mid-green at cnt=30 → cnt stays 3/0 and lamps hold; resumes decrementing after count_en=1.
- Reset=0 asserted at the same edge as a tick in phase 2 YELLOW → next state is phase 0 GREEN, cnt=green(0), green=0001, no cycle_start pulse.
- flowspeed=010 (undefined code) at cycle start → all greens 44.
